// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the four-requester memory port arbiter.
// Holds the FSM encoding, requester count and select width.
package mem_port_arbiter_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } arb_state_e;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick4.sv
// Combinational round-robin picker: first set req bit at or after start,
// wrapping, so the index just before start is the last candidate.
module rr_pick4
    import mem_port_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   start,
    output logic [SEL_W-1:0]   idx,
    output logic               valid
);

    logic             found;
    logic [SEL_W-1:0] cand;

    always_comb begin
        idx   = start;
        found = 1'b0;
        cand  = start;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = start + SEL_W'(k);
            if (!found && req[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
        valid = found;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter for a shared 32-bit port with four requesters.
// Define ARB_TIMEOUT_EN to add the forced-release counter and timeout pulse.
//
// state | meaning
// IDLE  | no owner; grant=0, busy=0, signal holds the previous owner
// OWNED | one requester owns the port until done (or timeout)
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
)
(
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    output logic [NUM_REQ-1:0] grant,
    output logic [SEL_W-1:0]   signal,
    output logic               busy
`ifdef ARB_TIMEOUT_EN
    ,
    output logic               timeout
`endif
);

    if ((1 << CNT_W) <= TIMEOUT_CYCLES) begin : g_bad_cnt_w
        $error("CNT_W too narrow for TIMEOUT_CYCLES");
    end

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [SEL_W-1:0]   signal_q, signal_d;
    logic [SEL_W-1:0]   last_q, last_d;
    logic               busy_q, busy_d;

    logic [SEL_W-1:0]   pick_idx;
    logic               pick_valid;
    logic               tmo_hit;
    logic               release_now;
    logic               take;

    rr_pick4 u_pick (
        .req   (req),
        .start (last_q + 2'd1),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    assign release_now = (state_q == OWNED) && (done || tmo_hit);
    assign take        = ((state_q == IDLE) || release_now) && pick_valid;

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        signal_d = signal_q;
        last_d   = last_q;
        busy_d   = busy_q;
        if (take) begin
            state_d  = OWNED;
            grant_d  = onehot(pick_idx);
            signal_d = pick_idx;
            last_d   = pick_idx;
            busy_d   = 1'b1;
        end else if (release_now) begin
            state_d = IDLE;
            grant_d = '0;
            busy_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            signal_q <= '0;
            last_q   <= 2'd3;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            signal_q <= signal_d;
            last_q   <= last_d;
            busy_q   <= busy_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q;

    // done wins over an expiring count, so tmo_hit requires !done
    assign tmo_hit = (state_q == OWNED) && !done &&
                     (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (take)
            cnt_d = '0;
        else if ((state_q == OWNED) && !done)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= tmo_hit;
        end
    end

    assign timeout = timeout_q;
`else
    assign tmo_hit = 1'b0;
`endif

    assign grant  = grant_q;
    assign signal = signal_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; the shared-port mux lives here.
// Timeout scenario runs only when ARB_TIMEOUT_EN is defined.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic        done;
    logic [3:0]  grant;
    logic [1:0]  signal;
    logic        busy;
`ifdef ARB_TIMEOUT_EN
    logic        timeout;
`endif

    int total = 0;
    int bad   = 0;

    logic [31:0] port_data [4];
    logic [31:0] mux_out;
    logic [6:0]  obs, exp;

    always #5 clk = ~clk;

    mem_port_arbiter #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .done   (done),
        .grant  (grant),
        .signal (signal),
        .busy   (busy)
`ifdef ARB_TIMEOUT_EN
        ,
        .timeout(timeout)
`endif
    );

    // 4:1 32-bit shared-port mux driven by the arbiter select
    assign mux_out = port_data[signal];

    assign obs = {grant, signal, busy};

    always @(negedge clk) begin
        total++;
        if ($countones(grant) > 1 || (busy && grant !== (4'b0001 << signal)) ||
            (!busy && grant !== 4'b0000)) begin
            bad++;
            $display("FAIL onehot_invariant grant=%b signal=%0d busy=%b", grant, signal, busy);
        end
    end

    task automatic test_reset();
        reset = 1'b1; req = 4'b0; done = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (obs !== 7'b0000_00_0) begin
            bad++; $display("FAIL reset_state got=%b expected=%b", obs, 7'b0000_00_0);
        end
`ifdef ARB_TIMEOUT_EN
        total++;
        if (timeout !== 1'b0) begin
            bad++; $display("FAIL reset_timeout got=%b expected=0", timeout);
        end
`endif
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (obs !== 7'b0000_00_0) begin
            bad++; $display("FAIL idle_no_req got=%b expected=%b", obs, 7'b0000_00_0);
        end
    endtask

    task automatic test_round_robin();
        int seq [5] = '{0, 1, 2, 3, 0};
        req = 4'b1111; done = 1'b0;
        for (int k = 0; k < 5; k++) begin
            exp = {4'b0001 << seq[k], 2'(seq[k]), 1'b1};
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                total++;
                if (obs !== exp) begin
                    bad++; $display("FAIL rr_owner k=%0d c=%0d got=%b expected=%b", k, c, obs, exp);
                end
                done = (c == 2);
                if (c == 2 && k == 4) req = 4'b0;
            end
            total++;
            if (mux_out !== 32'hC0DE_0000 + 32'(seq[k])) begin
                bad++; $display("FAIL rr_mux k=%0d got=%h expected=%h", k, mux_out, 32'hC0DE_0000 + 32'(seq[k]));
            end
        end
        @(negedge clk);
        total++;
        if (obs !== 7'b0000_00_0) begin
            bad++; $display("FAIL rr_to_idle got=%b expected=%b", obs, 7'b0000_00_0);
        end
        done = 1'b0;
    endtask

    task automatic test_single_owner();
        req = 4'b0100; done = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            total++;
            if (obs !== 7'b0100_10_1) begin
                bad++; $display("FAIL single_hold c=%0d got=%b expected=%b", c, obs, 7'b0100_10_1);
            end
            if (c == 5) begin done = 1'b1; req = 4'b0; end
        end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            total++;
            if (obs !== 7'b0000_10_0) begin
                bad++; $display("FAIL single_idle_hold c=%0d got=%b expected=%b", c, obs, 7'b0000_10_0);
            end
            done = 1'b0;
        end
    endtask

    task automatic test_req_change();
        req = 4'b0010; done = 1'b0;
        @(negedge clk);
        total++;
        if (obs !== 7'b0010_01_1) begin
            bad++; $display("FAIL chg_grant1 got=%b expected=%b", obs, 7'b0010_01_1);
        end
        req = 4'b1001;
        repeat (2) begin
            @(negedge clk);
            total++;
            if (obs !== 7'b0010_01_1) begin
                bad++; $display("FAIL chg_hold got=%b expected=%b", obs, 7'b0010_01_1);
            end
        end
        done = 1'b1;
        @(negedge clk);
        total++;
        if (obs !== 7'b1000_11_1) begin
            bad++; $display("FAIL chg_back_to_back got=%b expected=%b", obs, 7'b1000_11_1);
        end
        req = 4'b0;
        @(negedge clk);
        total++;
        if (obs !== 7'b0000_11_0) begin
            bad++; $display("FAIL chg_idle got=%b expected=%b", obs, 7'b0000_11_0);
        end
        done = 1'b0;
    endtask

    task automatic test_idle_done();
        req = 4'b0; done = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++;
            if (obs !== 7'b0000_11_0) begin
                bad++; $display("FAIL idle_done c=%0d got=%b expected=%b", c, obs, 7'b0000_11_0);
            end
        end
        done = 1'b0;
    endtask

    task automatic test_reset_owned();
        req = 4'b1111; done = 1'b0;
        @(negedge clk);
        total++;
        if (obs !== 7'b0001_00_1) begin
            bad++; $display("FAIL rst_pre0 got=%b expected=%b", obs, 7'b0001_00_1);
        end
        done = 1'b1;
        @(negedge clk);
        total++;
        if (obs !== 7'b0010_01_1) begin
            bad++; $display("FAIL rst_pre1 got=%b expected=%b", obs, 7'b0010_01_1);
        end
        done = 1'b0; reset = 1'b1;
        @(negedge clk);
        total++;
        if (obs !== 7'b0000_00_0) begin
            bad++; $display("FAIL rst_drop got=%b expected=%b", obs, 7'b0000_00_0);
        end
        done = 1'b1;
        @(negedge clk);
        total++;
        if (obs !== 7'b0000_00_0) begin
            bad++; $display("FAIL rst_ignore_inputs got=%b expected=%b", obs, 7'b0000_00_0);
        end
        reset = 1'b0; done = 1'b0;
        @(negedge clk);
        total++;
        if (obs !== 7'b0001_00_1) begin
            bad++; $display("FAIL rst_first_req0 got=%b expected=%b", obs, 7'b0001_00_1);
        end
        req = 4'b0001; done = 1'b1;
        @(negedge clk);
        total++;
        if (obs !== 7'b0001_00_1) begin
            bad++; $display("FAIL regrant_alone got=%b expected=%b", obs, 7'b0001_00_1);
        end
        req = 4'b1001;
        @(negedge clk);
        total++;
        if (obs !== 7'b1000_11_1) begin
            bad++; $display("FAIL owner_last got=%b expected=%b", obs, 7'b1000_11_1);
        end
        req = 4'b0;
        @(negedge clk);
        total++;
        if (obs !== 7'b0000_11_0) begin
            bad++; $display("FAIL rst_seq_idle got=%b expected=%b", obs, 7'b0000_11_0);
        end
        done = 1'b0;
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        req = 4'b0100; done = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            total++;
            if (obs !== 7'b0100_10_1 || timeout !== 1'b0) begin
                bad++; $display("FAIL tmo_hold c=%0d got=%b/%b expected=%b/0", c, obs, timeout, 7'b0100_10_1);
            end
            req = 4'b1100;
        end
        @(negedge clk);
        total++;
        if (obs !== 7'b1000_11_1 || timeout !== 1'b1) begin
            bad++; $display("FAIL tmo_release got=%b/%b expected=%b/1", obs, timeout, 7'b1000_11_1);
        end
        for (int c = 2; c <= 16; c++) begin
            @(negedge clk);
            total++;
            if (obs !== 7'b1000_11_1 || timeout !== 1'b0) begin
                bad++; $display("FAIL tmo_owner3 c=%0d got=%b/%b expected=%b/0", c, obs, timeout, 7'b1000_11_1);
            end
            done = (c == 16);
        end
        @(negedge clk);
        total++;
        if (obs !== 7'b0100_10_1 || timeout !== 1'b0) begin
            bad++; $display("FAIL tmo_done_wins got=%b/%b expected=%b/0", obs, timeout, 7'b0100_10_1);
        end
        req = 4'b0;
        @(negedge clk);
        total++;
        if (obs !== 7'b0000_10_0) begin
            bad++; $display("FAIL tmo_idle got=%b expected=%b", obs, 7'b0000_10_0);
        end
        done = 1'b0;
    endtask
`endif

    initial begin
        for (int i = 0; i < 4; i++) port_data[i] = 32'hC0DE_0000 + 32'(i);
        test_reset();
        test_round_robin();
        test_single_owner();
        test_req_change();
        test_idle_done();
        test_reset_owned();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`endif
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have exactly one clock, `clk`; reset, `reset`, SHALL be synchronous and active-high.
REQ-002 Parameter: TIMEOUT_CYCLES, default 16, maximum grant length in cycles without `done` (used only under REQ-024).
REQ-003 Parameter: CNT_W, default 5, width of the timeout counter; it SHALL satisfy 2^CNT_W > TIMEOUT_CYCLES.
REQ-004 Port `clk`: input, 1 bit, rising-edge clock.
REQ-005 Port `reset`: input, 1 bit, synchronous active-high reset.
REQ-006 Port `req`: input, 4 bits; req[i] means requester i wants the shared 32-bit port.
REQ-007 Port `done`: input, 1 bit; the shared resource finished the current transaction this cycle.
REQ-008 Port `grant`: output, 4 bits, one-hot or zero; identifies the current owner.
REQ-009 Port `signal`: output, 2 bits; binary index of the owner, drives the select of the 4:1 32-bit mux.
REQ-010 Port `busy`: output, 1 bit; a grant is active.
REQ-011 Port `timeout`: output, 1 bit; one-cycle pulse when a grant is forcibly released. It exists only under REQ-024.

Function
REQ-012 FSM states: IDLE and OWNED; all outputs SHALL be registered.
REQ-013 Round-robin search SHALL start at (last+1) mod 4 and pick the first set req bit; `last` is the most recently granted index.
REQ-014 In IDLE with req != 0, the next edge SHALL enter OWNED, set grant to one-hot(winner), set signal to the winner, set busy=1, and load last with the winner (one-cycle latency).
REQ-015 In IDLE with req == 0, the state SHALL remain IDLE and signal SHALL hold its previous value.
REQ-016 In OWNED, grant and signal SHALL stay stable until done=1 is sampled; changes to req during ownership SHALL be ignored.
REQ-017 In OWNED with done=1 and another request pending, the next owner SHALL be granted on the very next edge (back-to-back, no dead cycle).
REQ-018 The current owner SHALL be the last candidate in that search; it is re-granted only if no other req bit is set.
REQ-019 In OWNED with done=1 and req == 0, the block SHALL return to IDLE with grant=0, busy=0, and signal held.
REQ-020 done=1 sampled in IDLE SHALL be ignored.
REQ-021 No two grant bits SHALL ever be set at the same time; whenever busy=1, grant SHALL equal one-hot(signal).

Reset
REQ-022 Reset SHALL set state=IDLE, grant=0, signal=2'b00, busy=0, timeout=0, last=3 (so requester 0 wins first), and counter=0.
REQ-023 Reset asserted during OWNED SHALL drop the grant on that edge; req and done SHALL be ignored while reset=1.

Configuration
REQ-024 With ARB_TIMEOUT_EN defined:
- A counter SHALL clear on each new grant and increment each OWNED cycle without done.
- When the count reaches TIMEOUT_CYCLES-1 without done, the next edge SHALL release the owner exactly as if done=1, and pulse timeout for one cycle.
- done and timeout in the same cycle SHALL be treated as done, with no pulse.
REQ-025 Without ARB_TIMEOUT_EN, the counter and the `timeout` port SHALL be absent and a grant SHALL persist until done.

Structure
REQ-026 A shared package SHALL hold the FSM state encoding (IDLE=1'b0, OWNED=1'b1), the requester count constant (4), and the select width (2).
REQ-027 One sub-module, rr_pick4, SHALL be combinational: inputs req[3:0] and start[1:0]; outputs idx[1:0] and valid.
REQ-028 The block SHALL instantiate mux4 only in the testbench, never internally.

Verification
REQ-029 Reset release, then req=4'b1111 held and done pulsed every 3rd cycle -> grant sequence 0001, 0010, 0100, 1000, 0001, with signal 0,1,2,3,0.
REQ-030 req=4'b0100 only, done after 5 cycles -> grant=0100 one cycle after req, held 5 cycles, then IDLE with signal=2 held.
REQ-031 Owner 1 active, req changes to 4'b1001 mid-transfer -> grant stays 0010 until done, then 1000 next cycle with no gap.
REQ-032 done pulsed in IDLE with req=0 -> no state change and busy=0.
REQ-033 ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, owner 2 never asserts done -> release after 16 OWNED cycles, one-cycle timeout pulse, next requester granted.
REQ-034 reset asserted while OWNED with req=4'b1111 -> grant=0 next edge; after release, requester 0 is granted first.
